load_unit_ctrl: RTL

LOAD_UNIT_CTRL -- requirements
Module: load_unit_ctrl

---
 rtl/load_unit_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/load_unit_ctrl.sv
// Load unit controller: decodes a load, issues one aligned memory read,
// then extracts and extends the addressed lane for register writeback.
module load_unit_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [31:7]         instruction_code,
    input  logic [XLEN-1:0]     rs1_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_byte_en,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                illegal_exc,
    output logic                misalign_exc
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_W-1:0] r_memAddr;
    logic [NB-1:0]     r_byteEn;
    logic [2:0]        r_func3;
    logic [OFF_W-1:0]  r_off;
    logic [4:0]        r_rd;
    logic              r_wbValid;
    logic [4:0]        r_wbRd;
    logic [XLEN-1:0]   r_wbData;
    logic              r_illegal;
    logic              r_misalign;

    logic [11:0]       w_imm;
    logic [2:0]        w_func3;
    logic [4:0]        w_rd;
    logic [XLEN-1:0]   w_immExt;
    logic [XLEN-1:0]   w_sum;
    logic [ADDR_W-1:0] w_ea;
    logic [OFF_W-1:0]  w_off;
    logic [ADDR_W-1:0] w_memAddr;
    logic [NB-1:0]     w_sizeMask;
    logic [NB-1:0]     w_byteEn;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_accept;
    logic              w_launch;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_loadData;
    logic              w_unused;

    assign w_imm     = instruction_code[31:20];
    assign w_func3   = instruction_code[14:12];
    assign w_rd      = instruction_code[11:7];
    assign w_unused  = ^instruction_code[19:15];
    assign w_immExt  = XLEN'($signed(w_imm));
    assign w_sum     = rs1_data + w_immExt;
    assign w_ea      = ADDR_W'(w_sum);
    assign w_off     = w_ea[OFF_W-1:0];
    assign w_memAddr = {w_ea[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign w_byteEn  = w_sizeMask << w_off;
    assign w_accept  = inst_valid && (r_state == IDLE);
    assign w_launch  = w_accept && !w_illegal && !w_misalign;

    // Illegal takes priority over misalignment where both apply.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_sizeMask = '0;
        case (w_func3)
            3'd0, 3'd4: begin
                w_sizeMask = NB'(1);
            end
            3'd1, 3'd5: begin
                w_sizeMask = NB'(3);
                w_misalign = w_ea[0];
            end
            3'd2: begin
                w_sizeMask = NB'(4'hF);
                w_misalign = |w_ea[1:0];
            end
            3'd6: begin
                w_illegal  = (XLEN != 64);
                w_sizeMask = NB'(4'hF);
                w_misalign = |w_ea[1:0];
            end
            3'd3: begin
                w_illegal  = (XLEN != 64);
                w_sizeMask = '1;
                w_misalign = |w_ea[2:0];
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_shifted = mem_rsp_data >> {r_off, 3'b000};

    always_comb begin
        w_loadData = w_shifted;
        case (r_func3)
            3'd0:    w_loadData = XLEN'($signed(w_shifted[7:0]));
            3'd1:    w_loadData = XLEN'($signed(w_shifted[15:0]));
            3'd2:    w_loadData = XLEN'($signed(w_shifted[31:0]));
            3'd4:    w_loadData = XLEN'(w_shifted[7:0]);
            3'd5:    w_loadData = XLEN'(w_shifted[15:0]);
            3'd6:    w_loadData = XLEN'(w_shifted[31:0]);
            default: w_loadData = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        inst_ready    = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                inst_ready = 1'b1;
                if (w_launch) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    w_nextState = WB;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Writes to x0 still walk through WB but leave the writeback port untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memAddr  <= '0;
            r_byteEn   <= '0;
            r_func3    <= '0;
            r_off      <= '0;
            r_rd       <= '0;
            r_wbValid  <= 1'b0;
            r_wbRd     <= '0;
            r_wbData   <= '0;
            r_illegal  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_illegal  <= w_accept && w_illegal;
            r_misalign <= w_accept && !w_illegal && w_misalign;
            r_wbValid  <= 1'b0;
            if (w_launch) begin
                r_memAddr <= w_memAddr;
                r_byteEn  <= w_byteEn;
                r_func3   <= w_func3;
                r_off     <= w_off;
                r_rd      <= w_rd;
            end
            if ((r_state == WAIT) && mem_rsp_valid && (r_rd != 5'd0)) begin
                r_wbValid <= 1'b1;
                r_wbRd    <= r_rd;
                r_wbData  <= w_loadData;
            end
        end
    end

    assign mem_addr     = r_memAddr;
    assign mem_byte_en  = r_byteEn;
    assign wb_valid     = r_wbValid;
    assign wb_rd        = r_wbRd;
    assign wb_data      = r_wbData;
    assign illegal_exc  = r_illegal;
    assign misalign_exc = r_misalign;

endmodule
